// File: rtl/kbd_rx_fifo_pkg.sv
// kbd_rx_fifo_pkg: register map, STATUS bit positions and STATUS word packing shared by the keyboard RX FIFO
package kbd_rx_fifo_pkg;
  localparam logic [13:0] KBD_DATA_ADDR = 14'h1600;
  localparam logic [13:0] KBD_STAT_ADDR = 14'h1604;
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 8;
  localparam int ST_CNT_HI = 15;
  function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic ovf, input logic full, input logic empty);
    logic [31:0] w;
    w = '0;
    w[ST_CNT_HI:ST_CNT_LO] = cnt;
    w[ST_OVF] = ovf;
    w[ST_FULL] = full;
    w[ST_EMPTY] = empty;
    return w;
  endfunction
endpackage

// File: rtl/kbd_rx_fifo_sync_fifo.sv
// sync_fifo: circular FIFO (ports clk rst push pop din -> dout count full empty); pop ignored when empty, push dropped when full unless popping
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (PTR_W+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo: keyboard char FIFO for the CPU (clk rst key_asc key_en mem_addr mem_rd -> rd_data hit count), DATA read pops, STATUS read clears overflow
module kbd_rx_fifo
  import kbd_rx_fifo_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          PTR_W     = 4,
  parameter logic [13:0] DATA_ADDR = KBD_DATA_ADDR,
  parameter logic [13:0] STAT_ADDR = KBD_STAT_ADDR
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     key_asc,
  input  logic           key_en,
  input  logic [13:0]    mem_addr,
  input  logic           mem_rd,
  output logic [31:0]    rd_data,
  output logic           hit,
  output logic [PTR_W:0] count
);
  logic sync1, sync2, prev, ovf, push, pop, full, empty, data_sel, stat_sel;
  logic [7:0] dout;
  assign push = sync2 & ~prev;
  assign data_sel = mem_addr == DATA_ADDR;
  assign stat_sel = mem_addr == STAT_ADDR;
  assign pop = mem_rd & data_sel;
  assign hit = data_sel | stat_sel;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev <= 1'b0;
      ovf <= 1'b0;
    end else begin
      sync1 <= key_en;
      sync2 <= sync1;
      prev <= sync2;
      ovf <= (push & full & ~pop) | (ovf & ~(mem_rd & stat_sel));
    end
  always_comb
    rd_data = data_sel ? (empty ? 32'h0 : {24'h0, dout})
            : stat_sel ? status_word(8'(count), ovf, full, empty)
            : 32'h0;
  sync_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WIDTH(8)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(key_asc),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule
